// File: rtl/watchdog_timer.sv
// Watchdog timer with a RIB register interface.
// Counts down from LOAD; first expiry raises a warning, a second expiry (with
// RST_EN) holds a reset request for BITE_CYCLES cycles. A magic KICK write
// reloads the counter.
module watchdog_timer #(
    parameter int unsigned BITE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o,
    output logic        rst_req_o
);

    localparam logic [7:0]  AddrCtrl   = 8'h00;
    localparam logic [7:0]  AddrLoad   = 8'h04;
    localparam logic [7:0]  AddrCount  = 8'h08;
    localparam logic [7:0]  AddrKick   = 8'h0C;
    localparam logic [7:0]  AddrStatus = 8'h10;
    localparam logic [31:0] KickMagic  = 32'h5A5A_5A5A;

    localparam int unsigned BcW = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;
    localparam logic [BcW-1:0] BiteLast = BcW'(BITE_CYCLES - 1);

    // CTRL bit positions
    localparam int unsigned CtrlEn    = 0;
    localparam int unsigned CtrlIntEn = 1;
    localparam int unsigned CtrlRstEn = 2;
    localparam int unsigned CtrlLock  = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWarn = 2'd2,
        StBite = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [31:0]     load_q, load_d;
    logic [31:0]     count_q, count_d;
    logic            warn_pend_q, warn_pend_d;
    logic            bad_kick_q, bad_kick_d;
    logic [BcW-1:0]  bite_cnt_q, bite_cnt_d;

    logic            ctrl_we, load_we, kick_we, status_we;
    logic            locked, kick_ok, expired;

    // Only the low address byte is decoded.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:8];

    assign ctrl_we   = we_i && (addr_i[7:0] == AddrCtrl);
    assign load_we   = we_i && (addr_i[7:0] == AddrLoad);
    assign kick_we   = we_i && (addr_i[7:0] == AddrKick);
    assign status_we = we_i && (addr_i[7:0] == AddrStatus);
    assign locked    = ctrl_q[CtrlLock];
    assign kick_ok   = (data_i == KickMagic);
    assign expired   = (count_q == 32'd0);

    assign int_sig_o = warn_pend_q & ctrl_q[CtrlIntEn];
    assign rst_req_o = (state_q == StBite);

    // Combinational register read-back.
    always_comb begin
        data_o = 32'h0;
        case (addr_i[7:0])
            AddrCtrl:   data_o = {28'h0, ctrl_q};
            AddrLoad:   data_o = load_q;
            AddrCount:  data_o = count_q;
            AddrStatus: data_o = {28'h0, state_q, bad_kick_q, warn_pend_q};
            default:    data_o = 32'h0;
        endcase
    end

    // Next-state logic: bus writes first, then FSM so that hardware sets win over W1C.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        load_d      = load_q;
        count_d     = count_q;
        warn_pend_d = warn_pend_q;
        bad_kick_d  = bad_kick_q;
        bite_cnt_d  = bite_cnt_q;

        if (ctrl_we && !locked) begin
            ctrl_d = data_i[3:0];
        end
        if (load_we && !locked) begin
            load_d = data_i;
        end
        if (status_we) begin
            if (data_i[0]) warn_pend_d = 1'b0;
            if (data_i[1]) bad_kick_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (ctrl_we && !locked && data_i[CtrlEn]) begin
                    state_d = StRun;
                    count_d = load_q;
                end
            end
            StRun, StWarn: begin
                if (!ctrl_d[CtrlEn]) begin
                    // Disable: freeze COUNT where it is.
                    state_d = StIdle;
                end else if (kick_we && kick_ok) begin
                    state_d = StRun;
                    count_d = load_q;
                end else begin
                    if (kick_we) bad_kick_d = 1'b1;
                    if (expired) begin
                        if (state_q == StRun) begin
                            state_d     = StWarn;
                            warn_pend_d = 1'b1;
                            count_d     = load_q;
                        end else if (ctrl_q[CtrlRstEn]) begin
                            state_d    = StBite;
                            bite_cnt_d = '0;
                        end else begin
                            count_d = load_q;
                        end
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            StBite: begin
                // EN stays set until the bite completes; COUNT holds at 0.
                ctrl_d[CtrlEn] = 1'b1;
                if (bite_cnt_q == BiteLast) begin
                    state_d        = StIdle;
                    ctrl_d[CtrlEn] = 1'b0;
                end else begin
                    bite_cnt_d = bite_cnt_q + BcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            ctrl_q      <= 4'h0;
            load_q      <= 32'hFFFF_FFFF;
            count_q     <= 32'h0;
            warn_pend_q <= 1'b0;
            bad_kick_q  <= 1'b0;
            bite_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            load_q      <= load_d;
            count_q     <= count_d;
            warn_pend_q <= warn_pend_d;
            bad_kick_q  <= bad_kick_d;
            bite_cnt_q  <= bite_cnt_d;
        end
    end

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed bench for watchdog_timer with a scoreboard queue of expected values.
`timescale 1ns/1ps
module tb_watchdog_timer;

    localparam logic [31:0] ACtrl   = 32'h00;
    localparam logic [31:0] ALoad   = 32'h04;
    localparam logic [31:0] ACount  = 32'h08;
    localparam logic [31:0] AKick   = 32'h0C;
    localparam logic [31:0] AStatus = 32'h10;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_sig_o;
    logic        rst_req_o;

    int checks   = 0;
    int failures = 0;
    int hi_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    watchdog_timer #(.BITE_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .int_sig_o (int_sig_o),
        .rst_req_o (rst_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one write cycle; returns 1ns after the edge that commits it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(posedge clk);
        #1;
        we_i   = 1'b0;
        data_i = 32'h0;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed 0x%08h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] v);
        expect_val(tag, v);
        addr_i = a;
        #1;
        compare(data_o);
    endtask

    task automatic chk_sig(input string tag, input logic obs, input logic v);
        expect_val(tag, {31'h0, v});
        compare({31'h0, obs});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;
        do_reset();

        // Reset values
        chk_reg("rst_ctrl", ACtrl, 32'h0);
        chk_reg("rst_load", ALoad, 32'hFFFF_FFFF);
        chk_reg("rst_count", ACount, 32'h0);
        chk_reg("rst_status", AStatus, 32'h0);
        chk_sig("rst_int", int_sig_o, 1'b0);
        chk_sig("rst_req", rst_req_o, 1'b0);

        // LOAD=9, CTRL=0x3: WARN 10 cycles after enable
        bus_write(ALoad, 32'd9);
        bus_write(ACtrl, 32'h3);
        chk_reg("en_count", ACount, 32'd9);
        chk_reg("en_status", AStatus, 32'h4);
        tick(9);
        chk_reg("run_cnt0", ACount, 32'd0);
        chk_reg("run_pre_warn", AStatus, 32'h4);
        tick(1);
        chk_reg("warn_status", AStatus, 32'h9);
        chk_reg("warn_reload", ACount, 32'd9);
        chk_sig("warn_int", int_sig_o, 1'b1);
        // RST_EN=0: WARN expiry reloads and stays
        tick(10);
        chk_reg("warn_stay", AStatus, 32'h9);
        chk_reg("warn_stay_cnt", ACount, 32'd9);
        bus_write(AStatus, 32'h1);
        chk_reg("w1c_warn", AStatus, 32'h8);
        chk_sig("w1c_int", int_sig_o, 1'b0);
        // EN=0 -> IDLE with COUNT frozen
        bus_write(ACtrl, 32'h2);
        chk_reg("dis_status", AStatus, 32'h0);
        chk_reg("dis_count", ACount, 32'd8);
        tick(3);
        chk_reg("dis_hold", ACount, 32'd8);

        // LOAD=4, CTRL=0x7: WARN, BITE, 16-cycle reset request
        do_reset();
        bus_write(ALoad, 32'd4);
        bus_write(ACtrl, 32'h7);
        tick(4);
        chk_reg("b_run", AStatus, 32'h4);
        tick(1);
        chk_reg("b_warn", AStatus, 32'h9);
        chk_sig("b_noreq", rst_req_o, 1'b0);
        tick(4);
        chk_sig("b_noreq2", rst_req_o, 1'b0);
        tick(1);
        chk_reg("b_bite", AStatus, 32'hD);
        chk_reg("b_bite_cnt", ACount, 32'd0);
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (rst_req_o) hi_cnt++;
            if (!rst_req_o && hi_cnt > 0) break;
            // EN=0 mid-bite must not shorten it
            if (hi_cnt == 5) bus_write(ACtrl, 32'h6);
            else tick(1);
        end
        chk_reg("bite_len", AStatus, 32'h1);
        expect_val("bite_cycles", 32'd16);
        compare(hi_cnt);
        chk_reg("bite_ctrl", ACtrl, 32'h6);
        chk_reg("bite_count", ACount, 32'd0);
        chk_sig("bite_done", rst_req_o, 1'b0);

        // Valid kick on the expiry cycle wins
        do_reset();
        bus_write(ALoad, 32'd4);
        bus_write(ACtrl, 32'h1);
        tick(4);
        bus_write(AKick, 32'h5A5A_5A5A);
        chk_reg("kick_exp_cnt", ACount, 32'd4);
        chk_reg("kick_exp_st", AStatus, 32'h4);
        // Bad kick
        bus_write(AKick, 32'h1234);
        chk_reg("bad_kick_st", AStatus, 32'h6);
        chk_reg("bad_kick_cnt", ACount, 32'd3);
        tick(1);
        chk_reg("bad_kick_dec", ACount, 32'd2);
        bus_write(AStatus, 32'h2);
        chk_reg("bad_kick_w1c", AStatus, 32'h4);
        // LOAD write leaves COUNT alone
        bus_write(ALoad, 32'd2);
        chk_reg("load_no_cnt", ACount, 32'd0);
        // W1C coinciding with expiry: set wins
        bus_write(AStatus, 32'h1);
        chk_reg("set_wins", AStatus, 32'h9);
        chk_reg("new_load", ACount, 32'd2);
        bus_write(AKick, 32'h5A5A_5A5A);
        chk_reg("warn_kick", AStatus, 32'h5);
        // Kicks in IDLE are ignored; KICK/unmapped read as 0
        bus_write(ACtrl, 32'h0);
        bus_write(AKick, 32'h1234);
        chk_reg("idle_kick", AStatus, 32'h1);
        chk_reg("kick_rd", AKick, 32'h0);
        chk_reg("unmap_rd", 32'h20, 32'h0);

        // LOCK blocks CTRL/LOAD writes
        bus_write(ALoad, 32'd6);
        bus_write(ACtrl, 32'hF);
        bus_write(ACtrl, 32'h0);
        bus_write(ALoad, 32'd3);
        chk_reg("lock_ctrl", ACtrl, 32'hF);
        chk_reg("lock_load", ALoad, 32'd6);
        chk_reg("lock_cnt", ACount, 32'd4);
        chk_reg("lock_st", AStatus, 32'h5);
        chk_sig("lock_int", int_sig_o, 1'b1);
        bus_write(AStatus, 32'h1);
        chk_reg("lock_w1c", AStatus, 32'h4);

        // Reset during the 5th BITE cycle (LOAD=0 expires every cycle)
        do_reset();
        bus_write(ALoad, 32'd0);
        bus_write(ACtrl, 32'h5);
        tick(1);
        chk_reg("l0_warn", AStatus, 32'h9);
        tick(1);
        chk_sig("l0_bite", rst_req_o, 1'b1);
        tick(4);
        chk_sig("l0_bite5", rst_req_o, 1'b1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk_sig("ab_req", rst_req_o, 1'b0);
        chk_reg("ab_ctrl", ACtrl, 32'h0);
        chk_reg("ab_load", ALoad, 32'hFFFF_FFFF);
        chk_reg("ab_count", ACount, 32'h0);
        chk_reg("ab_status", AStatus, 32'h0);
        chk_sig("ab_int", int_sig_o, 1'b0);
        tick(2);
        chk_sig("ab_req_stay", rst_req_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
